// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_chk_if.sv
// Stimulus/response bundle between the dffq chain checker and its harness.
// The slave side is the checker; the master side is the chain plus readout.
interface gf180mcu_fd_sc_mcu9t5v0__dffq_chk_if;
  logic        START;
  logic        D;
  logic        Q;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] ERRCNT;

  modport slave (
    input  START,
    input  Q,
    output D,
    output BUSY,
    output DONE,
    output PASS,
    output ERRCNT
  );

  modport master (
    output START,
    output Q,
    input  D,
    input  BUSY,
    input  DONE,
    input  PASS,
    input  ERRCNT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_chk.sv
// Launches an LFSR bit stream into an N-stage dffq chain and counts tail
// mismatches against the bit launched N cycles earlier.
module gf180mcu_fd_sc_mcu9t5v0__dffq_chk #(
  parameter int unsigned N      = 8,
  parameter int unsigned CYCLES = 256,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  gf180mcu_fd_sc_mcu9t5v0__dffq_chk_if.slave     bus
);

  localparam int unsigned MAXC     = (N > CYCLES) ? N : CYCLES;
  localparam int unsigned CW       = $clog2(MAXC + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CW-1:0] N_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES - 1);
  localparam logic [15:0] ERR_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [15:0]    errcnt_q, errcnt_d;
  logic [N-1:0]   pipe_v_q, pipe_v_d;
  logic [N-1:0]   pipe_e_q, pipe_e_d;
  logic           d_q, d_d;
  logic           dv_q, dv_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           busy_c;
  logic           mismatch_c;

  // Next-state, pipe, compare and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    errcnt_d   = errcnt_q;
    pipe_v_d   = pipe_v_q;
    pipe_e_d   = pipe_e_q;
    d_d        = 1'b0;
    dv_d       = 1'b0;
    busy_c     = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_DRAIN);
    mismatch_c = pipe_v_q[N-1] && (bus.Q !== pipe_e_q[N-1]);

    // The pipe mirrors the chain: it takes the bit currently on D each edge.
    if (busy_c) begin
      pipe_v_d = N'({pipe_v_q, dv_q});
      pipe_e_d = N'({pipe_e_q, d_q});
      if (mismatch_c && (errcnt_q != ERR_MAX)) begin
        errcnt_d = errcnt_q + 16'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d  = S_FLUSH;
          cnt_d    = '0;
          lfsr_d   = SEED_EFF;
          errcnt_d = '0;
          pipe_v_d = '0;
          pipe_e_d = '0;
        end
      end
      S_FLUSH: begin
        if (cnt_q == N_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == CYC_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == N_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // D carries lfsr[0] for every cycle spent in RUN; the LFSR steps with it.
    if (state_d == S_RUN) begin
      d_d    = lfsr_q[0];
      dv_d   = 1'b1;
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    busy_d = (state_d == S_FLUSH) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (errcnt_d == 16'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= SEED_EFF;
      errcnt_q <= '0;
      pipe_v_q <= '0;
      pipe_e_q <= '0;
      d_q      <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      errcnt_q <= errcnt_d;
      pipe_v_q <= pipe_v_d;
      pipe_e_q <= pipe_e_d;
      d_q      <= d_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.D      = d_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.PASS   = pass_q;
  assign bus.ERRCNT = errcnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffq_chk.sv
// Bench: checker against modelled dffq chains (ideal, inverted, stuck-0, short)
// with expectations derived from the LFSR bit stream.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffq_chk;

  localparam int unsigned NA = 4;
  localparam int unsigned CA = 32;
  localparam int unsigned CB = 70000;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   mode;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [3:0] ca_q = '0;
  logic [3:0] cb_q = '0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__dffq_chk_if ifa ();
  gf180mcu_fd_sc_mcu9t5v0__dffq_chk_if ifb ();

  gf180mcu_fd_sc_mcu9t5v0__dffq_chk #(.N(NA), .CYCLES(CA), .SEED(16'hACE1)) dut_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (ifa)
  );

  gf180mcu_fd_sc_mcu9t5v0__dffq_chk #(.N(NA), .CYCLES(CB), .SEED(16'h0000)) dut_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (ifb)
  );

  // Chain models: 4 dffq stages; mode 0 ideal, 1 inverted, 2 stuck-0, 3 one stage short.
  always @(posedge clk) ca_q <= {ca_q[2:0], ifa.D};
  always @(posedge clk) cb_q <= {cb_q[2:0], ifb.D};
  assign ifa.Q = (mode == 0) ? ca_q[3] : (mode == 1) ? ~ca_q[3] : (mode == 2) ? 1'b0 : ca_q[2];
  assign ifb.Q = ~cb_q[3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // j-th bit of the run stream from seed ACE1.
  function automatic bit ref_bit(input int j);
    logic [15:0] l = 16'hACE1;
    for (int k = 0; k < j; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l[0];
  endfunction

  // Compare j sees the chain output of stream bit j + (NA - stages); zeros outside the run.
  function automatic int exp_err(input int m);
    int cnt = 0;
    for (int j = 0; j < int'(CA); j++) begin
      int src = (m == 3) ? j + 1 : j;
      bit sb  = (src < int'(CA)) ? ref_bit(src) : 1'b0;
      bit q   = (m == 0) ? sb : (m == 1) ? ~sb : (m == 2) ? 1'b0 : sb;
      if (q != ref_bit(j)) cnt++;
    end
    return cnt;
  endfunction

  task automatic run_a(input int m, input string tag, input bit poke_start);
    int busy_n = 0;
    int dmis   = 0;
    int exp    = exp_err(m);
    bit exp_d;
    mode = m;
    @(negedge clk) ifa.START = 1'b1;
    @(negedge clk) ifa.START = 1'b0;
    check_eq({tag, "_busy_rise"}, 32'(ifa.BUSY), 32'd1);
    while (ifa.BUSY === 1'b1 && busy_n < 200) begin
      exp_d = (busy_n >= int'(NA) && busy_n < int'(NA + CA)) ? ref_bit(busy_n - int'(NA)) : 1'b0;
      if (ifa.D !== exp_d) dmis++;
      ifa.START = (poke_start && busy_n == 20) ? 1'b1 : 1'b0;
      busy_n++;
      @(negedge clk);
    end
    ifa.START = 1'b0;
    check_eq({tag, "_busy_len"}, 32'(busy_n), 32'(2 * NA + CA));
    check_eq({tag, "_d_stream"}, 32'(dmis), 32'd0);
    check_eq({tag, "_done"}, 32'(ifa.DONE), 32'd1);
    check_eq({tag, "_pass"}, 32'(ifa.PASS), (exp == 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_errcnt"}, 32'(ifa.ERRCNT), 32'(exp));
    if (m == 3) check_eq({tag, "_errcnt_nz"}, 32'(ifa.ERRCNT != 16'd0), 32'd1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_errcnt_hold"}, 32'(ifa.ERRCNT), 32'(exp));
    check_eq({tag, "_done_hold"}, 32'(ifa.DONE), 32'd1);
  endtask

  initial begin
    int busy_n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_d", 32'(ifa.D), 32'd0);
    check_eq("rst_busy", 32'(ifa.BUSY), 32'd0);
    check_eq("rst_done", 32'(ifa.DONE), 32'd0);
    check_eq("rst_pass", 32'(ifa.PASS), 32'd0);
    check_eq("rst_errcnt", 32'(ifa.ERRCNT), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    run_a(0, "ideal", 1'b0);
    run_a(1, "inverted", 1'b0);
    run_a(2, "stuck0", 1'b0);
    run_a(3, "short", 1'b0);
    run_a(0, "start_busy", 1'b1);

    // Reset in RUN cycle 10 of an erroring run.
    mode = 1;
    @(negedge clk) ifa.START = 1'b1;
    @(negedge clk) ifa.START = 1'b0;
    busy_n = 0;
    while (busy_n < int'(NA) + 9 && ifa.BUSY === 1'b1) begin
      busy_n++;
      @(negedge clk);
    end
    check_eq("pre_rst_errcnt_nz", 32'(ifa.ERRCNT != 16'd0), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check_eq("midrst_busy", 32'(ifa.BUSY), 32'd0);
    check_eq("midrst_d", 32'(ifa.D), 32'd0);
    check_eq("midrst_errcnt", 32'(ifa.ERRCNT), 32'd0);
    check_eq("midrst_done", 32'(ifa.DONE), 32'd0);
    run_a(0, "after_rst", 1'b0);

    // RST and START together from DONE.
    @(negedge clk) begin
      rst_a = 1'b1;
      ifa.START = 1'b1;
    end
    @(negedge clk) begin
      rst_a = 1'b0;
      ifa.START = 1'b0;
    end
    check_eq("rst_start_busy", 32'(ifa.BUSY), 32'd0);
    check_eq("rst_start_done", 32'(ifa.DONE), 32'd0);
    @(negedge clk);
    check_eq("rst_start_idle", 32'(ifa.BUSY), 32'd0);

    // Saturation: inverted chain, 70000 compares; zero seed falls back to ACE1.
    @(negedge clk) ifb.START = 1'b1;
    @(negedge clk) ifb.START = 1'b0;
    busy_n = 0;
    while (ifb.BUSY === 1'b1 && busy_n < 80000) begin
      busy_n++;
      @(negedge clk);
    end
    check_eq("sat_busy_len", 32'(busy_n), 32'(2 * NA + CB));
    check_eq("sat_errcnt", 32'(ifb.ERRCNT), 32'h0000FFFF);
    check_eq("sat_pass", 32'(ifb.PASS), 32'd0);
    check_eq("sat_done", 32'(ifb.DONE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__dffq_chk.md
# gf180mcu_fd_sc_mcu9t5v0__dffq_chk

Self-checking stimulus/response block for characterising chains of `dffq` cells on silicon and in gate-level simulation. It drives a pseudo-random bit stream into the head of an N-stage `dffq` chain (the cells' `D`). It samples the chain tail (the last cell's `Q`) and counts mismatches against the bit it launched N cycles earlier. It sits beside the cell chain on the test-chip harness and reports `DONE`/`PASS`/`ERRCNT` to the scan/JTAG readout.

## Interface
- `N`, default 8: number of `dffq` stages in the chain under test (1..64).
- `CYCLES`, default 256: number of random bits launched and checked per run (1..2^20).
- `SEED`, default 16'hACE1: LFSR seed. A value of 0 is replaced by 16'hACE1.

Ports, clock and reset first:
- `CLK`  in  1: single clock, shared with the chain under test; all state updates on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `START`  in  1: run request, sampled on the rising edge.
- `D`  out  1: registered stimulus bit to the chain head.
- `Q`  in  1: chain tail output.
- `BUSY`  out  1: run in progress.
- `DONE`  out  1: run complete; held until the next accepted `START` or `RST`.
- `PASS`  out  1: `DONE` && `ERRCNT`==0.
- `ERRCNT`  out  16: mismatch count, saturating at 16'hFFFF.

## Operation
- **Reset (`RST`=1 at an edge, in any state):**
  - State goes to IDLE.
  - `D`=0, `BUSY`=0, `DONE`=0, `PASS`=0, `ERRCNT`=0.
  - LFSR reloads `SEED`; the expectation pipe and valid pipe are cleared.
- **States:** IDLE → FLUSH → RUN → DRAIN → DONE.
  - IDLE / DONE: a `START`=1 at an edge moves to FLUSH, clears `ERRCNT`, reloads the LFSR and clears `DONE`. In all other states `START` is ignored.
  - FLUSH, N cycles: `D`=0. The entries pushed are valid=0, so chain contents (possibly X) are never checked.
  - RUN, `CYCLES` cycles: `D`=`lfsr[0]`. The LFSR advances once per cycle. The entries pushed are valid=1 with expected=`D`.
  - DRAIN, N cycles: `D`=0 and the entries pushed are valid=0. Then go to DONE.
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift right, feedback into bit 15. The first RUN bit is `SEED[0]`.
- **Expectation pipe:** N entries of {valid, expected}, shifted every BUSY cycle in lock-step with `D`. The entry leaving the pipe corresponds to the bit currently present on `Q`, launched exactly N cycles earlier.
- **Compare:** when the departing entry has valid=1 and `Q`≠expected, `ERRCNT` increments, saturating at 16'hFFFF.
  - Exactly `CYCLES` compares happen per run; the last one falls in the final DRAIN cycle.
  - `Q`=X/Z counts as a mismatch (use a case-inequality compare).
- **Counters:** state counter is wide enough for max(N, `CYCLES`). `ERRCNT` never wraps.

## Timing
- `START` accepted at edge k: `BUSY`=1 and the first FLUSH `D`=0 appear after edge k.
- `BUSY` is high for exactly 2N+`CYCLES` cycles. `DONE` and `PASS` rise on the edge at which `BUSY` falls.
- The first random bit is driven after edge k+N. Its compare happens at edge k+2N+1, when `Q` shows the bit after N chain stages.
- `ERRCNT` is final when `DONE` rises and stable while `DONE`=1.
- `START` held high through a run is ignored. If `START` is still high in DONE, a new run begins at the next edge.
- Simultaneous `RST` and `START`: `RST` wins and the block stays in IDLE.
- `RST` mid-run: IDLE on the next edge with all outputs at reset values. No partial `ERRCNT` is retained.

## Test plan
- Ideal chain with N=4, `CYCLES`=32, `SEED`=16'hACE1, pulse `START`:
  - `BUSY` high for 40 cycles.
  - `D` during RUN matches the reference LFSR sequence.
  - `DONE`=1, `PASS`=1, `ERRCNT`=0.
- Chain with an inverted output (tail drives ~Q), N=4, `CYCLES`=32: `ERRCNT`=32, `PASS`=0.
- Tail stuck at 0, N=4, `CYCLES`=32: `ERRCNT` equals the number of ones in the first 32 LFSR output bits.
- Chain one stage short (3 stages, N=4): `ERRCNT`>0, and `DONE` still rises after exactly 40 `BUSY` cycles.
- `RST` asserted in RUN cycle 10:
  - Next cycle `BUSY`=0, `D`=0, `ERRCNT`=0.
  - A subsequent `START` runs a full clean pass.
- Saturation and start rules:
  - Inverted chain with `CYCLES`=70000 ends with `ERRCNT`=16'hFFFF.
  - A `START` pulse while `BUSY`=1 has no effect.
  - `RST` and `START` at the same edge leave the block in IDLE.
